// File: rtl/ram_sequencer.sv
// Arbitrates the 64 KB main RAM between a post-reset fill sweep, the HPS image download
// stream and the core RAM port; the core is held off while the sweep or a load runs.
module ram_sequencer #(
  parameter logic [7:0]  FILL     = 8'hFF,
  parameter logic [7:0]  DL_INDEX = 8'h01,
  parameter logic [15:0] DL_BASE  = 16'h0000,
  parameter int          CLR_BITS = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_we,
  input  logic        cpu_cs,
  output logic [7:0]  cpu_dout,
  output logic        cpu_hold,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  input  logic [7:0]  dl_index,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata,
  output logic        clr_done,
  output logic        dl_err
);

  typedef enum logic [1:0] {CLEAR = 2'd0, IDLE = 2'd1, LOAD = 2'd2} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CLR_BITS-1:0] clr_cnt;
  logic                pending;
  logic [15:0]         pend_addr;
  logic [7:0]          pend_data;

  logic idx_ok;
  logic dl_go;
  logic in_range;
  logic strobe;
  logic capture;
  logic drop;
  logic clr_last;

  assign idx_ok   = (dl_index == DL_INDEX);
  assign dl_go    = dl_active & idx_ok;
  assign in_range = (dl_addr[24:16] == 9'd0);
  assign strobe   = dl_wr & idx_ok;
  assign capture  = (state == LOAD) & strobe & in_range;
  // Any matching strobe that cannot be captured is a lost byte.
  assign drop     = strobe & ~capture;
  assign clr_last = &clr_cnt;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR: begin
        if (clr_last) begin
          state_nxt = dl_go ? LOAD : IDLE;
        end
      end
      IDLE: begin
        if (dl_go) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        // A byte captured as dl_active drops still needs its commit cycle in LOAD.
        if (!dl_active && !capture) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clr_cnt <= '0;
      pending <= 1'b0;
      dl_err  <= 1'b0;
    end else begin
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
      pending <= capture;
      if (drop) begin
        dl_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (capture) begin
      pend_addr <= DL_BASE + dl_addr[15:0];
      pend_data <= dl_data;
    end
  end

  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_din;
    ram_we    = 1'b0;
    cpu_dout  = FILL;
    cpu_hold  = 1'b1;
    clr_done  = 1'b0;
    case (state)
      CLEAR: begin
        ram_addr  = 16'(clr_cnt);
        ram_wdata = FILL;
        ram_we    = 1'b1;
        clr_done  = clr_last;
      end
      IDLE: begin
        ram_we   = cpu_we & cpu_cs;
        cpu_dout = ram_rdata;
        cpu_hold = 1'b0;
      end
      LOAD: begin
        ram_addr  = pend_addr;
        ram_wdata = pend_data;
        ram_we    = pending;
      end
      default: ;
    endcase
    if (reset) begin
      ram_we   = 1'b0;
      cpu_dout = FILL;
      cpu_hold = 1'b1;
      clr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_sequencer.sv
// Randomized scoreboard bench for ram_sequencer with a small RAM model and a reference memory.
module tb_ram_sequencer;

  localparam logic [15:0] BASE = 16'h0500;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_we;
  logic        cpu_cs;
  logic [7:0]  cpu_dout;
  logic        cpu_hold;
  logic        dl_active;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic [7:0]  dl_index;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;
  logic        clr_done;
  logic        dl_err;

  always #5 clk_sys = ~clk_sys;

  ram_sequencer #(
    .FILL(8'hFF), .DL_INDEX(8'h01), .DL_BASE(BASE), .CLR_BITS(4)
  ) dut (
    .clk_sys(clk_sys), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we), .cpu_cs(cpu_cs),
    .cpu_dout(cpu_dout), .cpu_hold(cpu_hold),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .dl_index(dl_index),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .clr_done(clr_done), .dl_err(dl_err)
  );

  bit [7:0] mem [0:65535];
  bit [7:0] ref_mem [0:65535];

  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  logic [23:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic        rd_issue;
  int          total;
  int          bad;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
    exp_wr.push_back({a, d});
    ref_mem[a] = d;
  endtask

  task automatic issue_rd(input logic [15:0] a);
    cpu_addr = a;
    cpu_cs   = 1'b1;
    cpu_we   = 1'b0;
    rd_issue = 1'b1;
    exp_rd.push_back(ref_mem[a]);
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_addr = '0; cpu_din = '0; cpu_we = 1'b0; cpu_cs = 1'b0; rd_issue = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] e;
    logic [15:0] a;
    logic [7:0]  d;
    logic        rd_q;
    total = 0; bad = 0; rd_q = 1'b0;
    reset = 1'b1;
    idle_inputs();
    dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0; dl_index = 8'h01;

    // Scoreboard monitor: every RAM write and every delayed read result is popped and compared.
    fork
      forever begin
        @(negedge clk_sys);
        if (ram_we === 1'b1) begin
          if (exp_wr.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h want none", ram_addr, ram_wdata);
          end else begin
            e = exp_wr.pop_front();
            chk("wr_addr", int'(ram_addr), int'(e[23:8]));
            chk("wr_data", int'(ram_wdata), int'(e[7:0]));
          end
        end
        if (rd_q) begin
          if (exp_rd.size() == 0) begin
            total++; bad++;
            $display("FAIL rd_queue: got empty queue want entry");
          end else begin
            d = exp_rd.pop_front();
            chk("rd_data", int'(cpu_dout), int'(d));
          end
        end
        rd_q = rd_issue;
      end
    join_none

    step();
    @(negedge clk_sys);
    chk("rst_we", ram_we, 0);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_done", clr_done, 0);
    chk("rst_dout", cpu_dout, 8'hFF);
    chk("rst_err", dl_err, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) push_wr(16'(i), 8'hFF);

    for (int i = 1; i <= 17; i++) begin
      @(negedge clk_sys);
      chk("sweep_done", clr_done, (i == 16) ? 1 : 0);
      chk("sweep_hold", cpu_hold, (i <= 16) ? 1 : 0);
      step();
    end

    cpu_addr = 16'h1234; cpu_din = 8'h5A; cpu_we = 1'b1; cpu_cs = 1'b1;
    push_wr(16'h1234, 8'h5A);
    @(negedge clk_sys);
    chk("pass_we", ram_we, 1);
    chk("pass_addr", ram_addr, 16'h1234);
    step();
    issue_rd(16'h1234);
    step();
    idle_inputs();

    for (int i = 0; i < 60; i++) begin
      a = {11'h091, 5'($urandom_range(0, 31))};
      if ($urandom_range(0, 1) == 1) begin
        d = 8'($urandom);
        cpu_addr = a; cpu_din = d; cpu_we = 1'b1; cpu_cs = 1'b1; rd_issue = 1'b0;
        push_wr(a, d);
      end else begin
        issue_rd(a);
      end
      step();
    end
    idle_inputs();
    step();

    dl_active = 1'b1; dl_index = 8'h01;
    @(negedge clk_sys);
    chk("load_hold_lag", cpu_hold, 0);
    step();
    cpu_we = 1'b1; cpu_cs = 1'b1; cpu_addr = 16'h0500; cpu_din = 8'hEE;
    @(negedge clk_sys);
    chk("load_hold", cpu_hold, 1);
    chk("load_dout", cpu_dout, 8'hFF);
    chk("load_core_we", ram_we, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      dl_wr = 1'b1; dl_addr = 25'(i); dl_data = 8'(8'h11 * (i + 1));
      push_wr(BASE + 16'(i), dl_data);
      @(negedge clk_sys);
      chk("dl_hold", cpu_hold, 1);
      chk("dl_we_lat", ram_we, (i == 0) ? 0 : 1);
    end
    step();
    dl_wr = 1'b0; dl_active = 1'b0;
    idle_inputs();
    @(negedge clk_sys);
    chk("dl_commit_we", ram_we, 1);
    chk("dl_commit_addr", ram_addr, 16'h0502);
    chk("dl_commit_hold", cpu_hold, 1);
    step();
    @(negedge clk_sys);
    chk("dl_exit_hold", cpu_hold, 0);
    step();

    dl_active = 1'b1;
    step();
    for (int i = 0; i < 40; i++) begin
      dl_wr    = 1'($urandom_range(0, 1));
      dl_index = ($urandom_range(0, 4) == 0) ? 8'h02 : 8'h01;
      a        = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 63));
      dl_addr  = {9'd0, a};
      dl_data  = 8'($urandom);
      cpu_we   = 1'($urandom_range(0, 1));
      cpu_cs   = 1'($urandom_range(0, 1));
      cpu_addr = 16'($urandom);
      if (dl_wr && dl_index == 8'h01) push_wr(BASE + a, dl_data);
      step();
    end
    dl_wr = 1'b0; dl_active = 1'b0; dl_index = 8'h01;
    idle_inputs();
    step();
    step();
    @(negedge clk_sys);
    chk("burst_exit_hold", cpu_hold, 0);
    chk("mismatch_no_err", dl_err, 0);
    step();
    issue_rd(16'h04FF);
    step();
    for (int i = 0; i < 20; i++) begin
      issue_rd(BASE + 16'($urandom_range(0, 63)));
      step();
    end
    idle_inputs();
    step();

    dl_active = 1'b1;
    step();
    dl_wr = 1'b1; dl_addr = 25'h10000; dl_data = 8'h44;
    step();
    dl_wr = 1'b0;
    @(negedge clk_sys);
    chk("oor_we", ram_we, 0);
    chk("oor_err", dl_err, 1);
    step();
    dl_active = 1'b0;
    step();
    step();
    @(negedge clk_sys);
    chk("oor_err_sticky", dl_err, 1);
    chk("oor_exit_hold", cpu_hold, 0);
    step();

    dl_active = 1'b1;
    step();
    dl_wr = 1'b1; dl_addr = 25'h7; dl_data = 8'h99;
    step();
    dl_wr = 1'b0; dl_active = 1'b0; reset = 1'b1;
    @(negedge clk_sys);
    chk("rst_load_we", ram_we, 0);
    step();
    reset = 1'b0; dl_active = 1'b1; dl_index = 8'h01;
    for (int i = 0; i < 16; i++) push_wr(16'(i), 8'hFF);
    for (int i = 1; i <= 16; i++) begin
      dl_wr = (i == 3);
      dl_addr = 25'h3; dl_data = 8'h55;
      @(negedge clk_sys);
      if (i == 1) chk("rst_clears_err", dl_err, 0);
      if (i == 4) chk("sweep_drop_err", dl_err, 1);
      chk("sweep2_done", clr_done, (i == 16) ? 1 : 0);
      chk("sweep2_hold", cpu_hold, 1);
      step();
    end
    dl_wr = 1'b1; dl_addr = 25'h5; dl_data = 8'h77;
    push_wr(BASE + 16'h5, 8'h77);
    @(negedge clk_sys);
    chk("direct_load_hold", cpu_hold, 1);
    chk("direct_load_we", ram_we, 0);
    step();
    dl_wr = 1'b0; dl_active = 1'b0;
    @(negedge clk_sys);
    chk("direct_load_commit", ram_we, 1);
    step();
    @(negedge clk_sys);
    chk("final_hold", cpu_hold, 0);
    step();
    issue_rd(BASE + 16'h5);
    step();
    idle_inputs();
    step();
    step();

    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("rd_queue_empty", exp_rd.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
